// File: rtl/dev_bridge_pkg.sv
// Shared types and sizes for the CPU-to-peripheral address-decoding bridge.
//   state_t : bridge sequencing states (IDLE, ISSUE, RESP)
//   NDEV    : number of device windows
//   CNT_W   : width of the ISSUE-cycle timeout counter
package dev_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int unsigned NDEV        = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W       = $clog2(TIMEOUT_DEF);

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational window decoder: compares the address tag against each
// device base tag; the lowest matching index wins.
//   addr_i      : request byte address
//   base_tags_i : base addresses with the in-window offset bits dropped
//   hit_o       : one-hot winning window
//   idx_o       : index of the winning window
//   any_o       : at least one window matched
//   misal_o     : address not word aligned
//   offset_o    : byte offset inside the window
module bridge_addr_decode
  import dev_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WIN_BITS = 4
) (
  input  logic [ADDR_W-1:0]                   addr_i,
  input  logic [NDEV-1:0][ADDR_W-WIN_BITS-1:0] base_tags_i,
  output logic [NDEV-1:0]                     hit_o,
  output logic [IDX_W-1:0]                    idx_o,
  output logic                                any_o,
  output logic                                misal_o,
  output logic [WIN_BITS-1:0]                 offset_o
);

  logic [NDEV-1:0] raw_c;

  always_comb begin
    raw_c = '0;
    for (int i = 0; i < NDEV; i++) begin
      raw_c[i] = (addr_i[ADDR_W-1:WIN_BITS] == base_tags_i[i]);
    end
  end

  // Isolate the lowest set bit so overlapping windows still yield one-hot.
  assign hit_o = raw_c & NDEV'(~raw_c + NDEV'(1));

  always_comb begin
    idx_o = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (raw_c[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o    = |raw_c;
  assign misal_o  = |addr_i[1:0];
  assign offset_o = addr_i[WIN_BITS-1:0];

endmodule

// File: rtl/dev_bridge.sv
// Address-decoding bridge from the CPU data port to four peripherals.
// Accepts one request, drives the selected device until it acknowledges
// (or times out), then returns data/error over a valid/ready response.
//   clk, reset           : clock, async active-high reset
//   req_*                : CPU request (valid/ready, we, addr, wdata, be)
//   dev_sel/we/addr/...  : registered device-side strobes and payload
//   dev_ack, dev_rdata   : per-device acknowledge and flattened read data
//   rsp_*                : CPU response (valid/ready, rdata, err)
module dev_bridge
  import dev_bridge_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        WIN_BITS = 4,
  parameter logic [ADDR_W-1:0]  BASE0    = 32'h0000_7F00,
  parameter logic [ADDR_W-1:0]  BASE1    = 32'h0000_7F10,
  parameter logic [ADDR_W-1:0]  BASE2    = 32'h0000_7F20,
  parameter logic [ADDR_W-1:0]  BASE3    = 32'h0000_7F30,
  parameter int unsigned        TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [BE_W-1:0]          req_be,
  output logic [NDEV-1:0]          dev_sel,
  output logic                     dev_we,
  output logic [WIN_BITS-1:0]      dev_addr,
  output logic [DATA_W-1:0]        dev_wdata,
  output logic [BE_W-1:0]          dev_be,
  input  logic [NDEV-1:0]          dev_ack,
  input  logic [NDEV*DATA_W-1:0]   dev_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err
);

  localparam int unsigned TAG_W = ADDR_W - WIN_BITS;

  logic [NDEV-1:0][TAG_W-1:0] base_tags;
  logic [NDEV-1:0]            dec_hit;
  logic [IDX_W-1:0]           dec_idx;
  logic                       dec_any;
  logic                       dec_misal;
  logic [WIN_BITS-1:0]        dec_offset;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NDEV-1:0]       dev_sel_q, dev_sel_d;
  logic                  dev_we_q, dev_we_d;
  logic [WIN_BITS-1:0]   dev_addr_q, dev_addr_d;
  logic [DATA_W-1:0]     dev_wdata_q, dev_wdata_d;
  logic [BE_W-1:0]       dev_be_q, dev_be_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  ack_sel;
  logic                  timed_out;
  logic                  go_issue;

  assign base_tags[0] = BASE0[ADDR_W-1:WIN_BITS];
  assign base_tags[1] = BASE1[ADDR_W-1:WIN_BITS];
  assign base_tags[2] = BASE2[ADDR_W-1:WIN_BITS];
  assign base_tags[3] = BASE3[ADDR_W-1:WIN_BITS];

  bridge_addr_decode #(
    .ADDR_W   (ADDR_W),
    .WIN_BITS (WIN_BITS)
  ) u_decode (
    .addr_i      (req_addr),
    .base_tags_i (base_tags),
    .hit_o       (dec_hit),
    .idx_o       (dec_idx),
    .any_o       (dec_any),
    .misal_o     (dec_misal),
    .offset_o    (dec_offset)
  );

  // Only the latched device's acknowledge counts; the ack beats a timeout.
  assign ack_sel   = dev_ack[idx_q];
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign go_issue  = dec_any && !dec_misal;

  // State and registered outputs; async reset clears strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      dev_sel_q   <= '0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      dev_be_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dev_sel_q   <= dev_sel_d;
      dev_we_q    <= dev_we_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      dev_be_q    <= dev_be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = go_issue ? ISSUE : RESP;
      ISSUE:   if (ack_sel || timed_out) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dev_sel_d   = dev_sel_q;
    dev_we_d    = dev_we_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    dev_be_d    = dev_be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d       = dec_idx;
          dev_addr_d  = dec_offset;
          dev_wdata_d = req_wdata;
          dev_be_d    = req_be;
          if (go_issue) begin
            dev_sel_d = dec_hit;
            dev_we_d  = req_we;
            cnt_d     = '0;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (ack_sel || timed_out) begin
          dev_sel_d   = '0;
          dev_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !ack_sel;
          rsp_rdata_d = (ack_sel && !dev_we_q) ? dev_rdata[{idx_q, 5'd0} +: DATA_W] : '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        dev_sel_d   = '0;
        dev_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign dev_sel   = dev_sel_q;
  assign dev_we    = dev_we_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wdata = dev_wdata_q;
  assign dev_be    = dev_be_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
